// File: rtl/button_press_counter.sv
// Push-button press counter: two-flop synchroniser, restartable debounce, press/long-hold FSM.
// The 8-bit count is shown on LED_OUT. A long hold clears it and emits CLEAR_PULSE.
module button_press_counter #(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned LONG_PRESS_CYCLES = 12000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_IN,
  output logic [7:0] LED_OUT,
  output logic       DEBOUNCED,
  output logic       PRESS_PULSE,
  output logic       CLEAR_PULSE
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  // Clear fires on the edge where the hold counter steps onto LONG_PRESS_CYCLES-1.
  localparam logic [HoldW-1:0] HoldClr = HoldW'(LONG_PRESS_CYCLES - 2);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLongHeld
  } state_e;

  logic             r_sync1;
  logic             r_sync_q;
  logic [DbW-1:0]   r_db_cnt;
  logic [DbW-1:0]   w_db_cnt_next;
  logic             r_deb;
  logic             w_deb_next;
  logic             w_differ;
  logic             w_accept;
  logic             w_deb_rise;
  logic             w_deb_fall;

  state_e           r_state;
  state_e           w_state_next;
  logic [HoldW-1:0] r_hold;
  logic [HoldW-1:0] w_hold_next;
  logic [7:0]       r_count;
  logic [7:0]       w_count_next;
  logic             r_press;
  logic             w_press_next;
  logic             r_clear;
  logic             w_clear_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1  <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync1  <= BTN_IN;
      r_sync_q <= r_sync1;
    end
  end

  assign w_differ   = (r_sync_q != r_deb);
  assign w_accept   = w_differ && (r_db_cnt == DbLast);
  assign w_deb_rise = w_accept && r_sync_q;
  assign w_deb_fall = w_accept && !r_sync_q;

  always_comb begin
    w_db_cnt_next = '0;
    w_deb_next    = r_deb;
    if (w_differ) begin
      if (w_accept) begin
        w_deb_next = r_sync_q;
      end else begin
        w_db_cnt_next = r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_db_cnt <= '0;
      r_deb    <= 1'b0;
    end else begin
      r_db_cnt <= w_db_cnt_next;
      r_deb    <= w_deb_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_count_next = r_count;
    w_press_next = 1'b0;
    w_clear_next = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_deb_rise) begin
          w_count_next = r_count + 8'd1;
          w_press_next = 1'b1;
          w_hold_next  = '0;
          w_state_next = StPressed;
        end
      end
      StPressed: begin
        if (w_deb_fall) begin
          w_state_next = StIdle;
        end else if (r_hold == HoldClr) begin
          w_hold_next  = r_hold + 1'b1;
          w_count_next = 8'd0;
          w_clear_next = 1'b1;
          w_state_next = StLongHeld;
        end else begin
          w_hold_next = r_hold + 1'b1;
        end
      end
      StLongHeld: begin
        if (w_deb_fall) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
      r_hold  <= '0;
      r_count <= 8'd0;
      r_press <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_count <= w_count_next;
      r_press <= w_press_next;
      r_clear <= w_clear_next;
    end
  end

  assign LED_OUT     = r_count;
  assign DEBOUNCED   = r_deb;
  assign PRESS_PULSE = r_press;
  assign CLEAR_PULSE = r_clear;

endmodule

// File: tb/tb_button_press_counter.sv
// Bench for button_press_counter: directed scenarios plus random button traffic, all
// outputs compared every cycle against a sample-window reference model.
module tb_button_press_counter;

  localparam int unsigned D = 4;
  localparam int unsigned L = 40;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_IN;
  logic [7:0] LED_OUT;
  logic       DEBOUNCED;
  logic       PRESS_PULSE;
  logic       CLEAR_PULSE;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #42 CLK = ~CLK;

  button_press_counter #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_IN     (BTN_IN),
    .LED_OUT    (LED_OUT),
    .DEBOUNCED  (DEBOUNCED),
    .PRESS_PULSE(PRESS_PULSE),
    .CLEAR_PULSE(CLEAR_PULSE)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the debounced level flips once the last D synchronised samples all
  // disagree with it; each rise is a press; a level held L-1 edges past its rise clears.
  logic q_hist[$];
  bit   m_deb, m_press, m_clear, m_cleared;
  int   m_count, m_rise, m_n;

  task automatic model_reset();
    q_hist.delete();
    for (int i = 0; i < int'(D) + 2; i++) q_hist.push_back(1'b0);
    m_deb = 0; m_press = 0; m_clear = 0; m_cleared = 0;
    m_count = 0; m_rise = 0; m_n = 0;
  endtask

  task automatic model_step();
    bit flip;
    flip = 1'b1;
    m_n++;
    m_press = 0;
    m_clear = 0;
    // Samples seen by the second sync flop at this edge are two edges old.
    for (int i = 0; i < int'(D); i++)
      if (q_hist[q_hist.size() - 2 - i] == m_deb) flip = 1'b0;
    q_hist.push_back(BTN_IN);
    void'(q_hist.pop_front());
    if (flip) begin
      m_deb = !m_deb;
      if (m_deb) begin
        m_count   = (m_count + 1) % 256;
        m_press   = 1;
        m_rise    = m_n;
        m_cleared = 0;
      end
    end else if (m_deb && !m_cleared && (m_n - m_rise == int'(L) - 1)) begin
      m_count   = 0;
      m_clear   = 1;
      m_cleared = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) model_reset();
      else model_step();
    end
  end

  initial begin
    wait (chk_en);
    forever begin
      @(negedge CLK);
      check_eq("cyc_led", int'(LED_OUT), m_count);
      check_eq("cyc_deb", int'(DEBOUNCED), int'(m_deb));
      check_eq("cyc_press", int'(PRESS_PULSE), int'(m_press));
      check_eq("cyc_clear", int'(CLEAR_PULSE), int'(m_clear));
    end
  end

  // Entered and left at posedge+5. Edge numbers are 1-based from the level change.
  task automatic hold_level(input logic lvl, input int n, output int deb_edge,
                            output int chg_edge, output int zero_edge,
                            output int n_press, output int n_clear);
    logic       deb0;
    logic [7:0] led0;
    deb0 = DEBOUNCED;
    led0 = LED_OUT;
    deb_edge = -1; chg_edge = -1; zero_edge = -1; n_press = 0; n_clear = 0;
    BTN_IN = lvl;
    for (int k = 1; k <= n; k++) begin
      @(posedge CLK);
      #1;
      if (deb_edge < 0 && DEBOUNCED != deb0) deb_edge = k;
      if (chg_edge < 0 && LED_OUT != led0) chg_edge = k;
      if (zero_edge < 0 && LED_OUT == 8'd0) zero_edge = k;
      n_press += int'(PRESS_PULSE);
      n_clear += int'(CLEAR_PULSE);
      #4;
    end
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #5;
    end
    RST = 1'b0;
  endtask

  int de, ce, ze, np, nc, tot;

  initial begin
    RST = 1'b1;
    BTN_IN = 1'b0;
    #100;
    check_eq("rst_led", int'(LED_OUT), 0);
    check_eq("rst_deb", int'(DEBOUNCED), 0);
    check_eq("rst_press", int'(PRESS_PULSE), 0);
    check_eq("rst_clear", int'(CLEAR_PULSE), 0);
    chk_en = 1'b1;
    RST = 1'b0;
    @(posedge CLK);
    #5;

    hold_level(1'b0, 100, de, ce, ze, np, nc);
    check_eq("idle_deb_edge", de, -1);
    check_eq("idle_press", np, 0);
    check_eq("idle_led", int'(LED_OUT), 0);

    // Clean press and release
    hold_level(1'b1, 20, de, ce, ze, np, nc);
    check_eq("press_deb_lat", de, 6);
    check_eq("press_led_lat", ce, 6);
    check_eq("press_pulses", np, 1);
    check_eq("press_led", int'(LED_OUT), 1);
    hold_level(1'b0, 20, de, ce, ze, np, nc);
    check_eq("release_deb_lat", de, 6);
    check_eq("release_led", int'(LED_OUT), 1);
    check_eq("release_pulses", np, 0);

    // Bounce then steady high
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      hold_level((i % 2 == 0) ? 1'b1 : 1'b0, 2, de, ce, ze, np, nc);
      tot += np;
    end
    hold_level(1'b1, 20, de, ce, ze, np, nc);
    tot += np;
    check_eq("bounce_pulses", tot, 1);
    check_eq("bounce_led", int'(LED_OUT), 2);
    hold_level(1'b0, 20, de, ce, ze, np, nc);

    // Short glitch must be rejected
    hold_level(1'b1, 3, de, ce, ze, np, nc);
    tot = np;
    check_eq("glitch_deb_hi", de, -1);
    hold_level(1'b0, 20, de, ce, ze, np, nc);
    tot += np;
    check_eq("glitch_deb_lo", de, -1);
    check_eq("glitch_pulses", tot, 0);
    check_eq("glitch_led", int'(LED_OUT), 2);

    // Long press from 5
    repeat (3) begin
      hold_level(1'b1, 10, de, ce, ze, np, nc);
      hold_level(1'b0, 10, de, ce, ze, np, nc);
    end
    check_eq("pre_long_led", int'(LED_OUT), 5);
    hold_level(1'b1, 100, de, ce, ze, np, nc);
    check_eq("long_inc_edge", ce, 6);
    check_eq("long_zero_edge", ze, 45);
    check_eq("long_clears", nc, 1);
    check_eq("long_presses", np, 1);
    check_eq("long_led", int'(LED_OUT), 0);
    hold_level(1'b0, 20, de, ce, ze, np, nc);
    check_eq("long_rel_clears", nc, 0);
    check_eq("long_rel_led", int'(LED_OUT), 0);
    hold_level(1'b1, 10, de, ce, ze, np, nc);
    check_eq("after_long_led", int'(LED_OUT), 1);
    hold_level(1'b0, 10, de, ce, ze, np, nc);

    // 256 presses from reset wrap to 0
    do_reset(3);
    tot = 0;
    for (int p = 1; p <= 256; p++) begin
      hold_level(1'b1, 8, de, ce, ze, np, nc);
      tot += np;
      if (p == 255) check_eq("wrap_255", int'(LED_OUT), 255);
      if (p == 256) check_eq("wrap_256", int'(LED_OUT), 0);
      hold_level(1'b0, 8, de, ce, ze, np, nc);
    end
    check_eq("wrap_pulses", tot, 256);

    // Reset while held in the pressed state
    hold_level(1'b1, 10, de, ce, ze, np, nc);
    check_eq("mid_pre_led", int'(LED_OUT), 1);
    RST = 1'b1;
    #1;
    check_eq("mid_rst_led", int'(LED_OUT), 0);
    check_eq("mid_rst_deb", int'(DEBOUNCED), 0);
    check_eq("mid_rst_press", int'(PRESS_PULSE), 0);
    check_eq("mid_rst_clear", int'(CLEAR_PULSE), 0);
    repeat (5) @(posedge CLK);
    #5;
    RST = 1'b0;
    hold_level(1'b1, 10, de, ce, ze, np, nc);
    check_eq("mid_led_lat", ce, 6);
    check_eq("mid_deb_lat", de, 6);
    check_eq("mid_led", int'(LED_OUT), 1);
    hold_level(1'b0, 10, de, ce, ze, np, nc);

    // Random traffic, checked each cycle by the model
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(int'($urandom_range(1, 4)));
      end else begin
        int len;
        len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 90))
                                          : int'($urandom_range(1, 12));
        hold_level(logic'($urandom_range(0, 1)), len, de, ce, ze, np, nc);
      end
    end
    hold_level(1'b0, 20, de, ce, ze, np, nc);
    check_eq("final_deb", int'(DEBOUNCED), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_press_counter.md
Name: button_press_counter

Overview:
- Input-side counterpart to the binary LED counter. The LED counter drives time onto LED_OUT; this block reads a raw push-button, synchronises and debounces it, and counts clean presses onto the same 8-LED bank.
- A long hold clears the count.
- Sits between the board button pin and the LED pins, in the 12 MHz CLK domain.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable clocks needed to accept a new button level (10 ms at 12 MHz). Must be ≥1.
- LONG_PRESS_CYCLES, 12000000, clocks the debounced level must stay high before a clear (1 s at 12 MHz). Must be > DEBOUNCE_CYCLES.
- Benches reduce both values so simulation finishes in short time.

Ports:
- CLK  input  1  system clock, 12 MHz, rising-edge.
- RST  input  1  asynchronous, active-high reset; clears all state immediately.
- BTN_IN  input  1  raw, asynchronous, bouncing button level; 1 = pressed.
- LED_OUT  output  8  press count, unsigned.
- DEBOUNCED  output  1  debounced button level.
- PRESS_PULSE  output  1  one-cycle strobe per accepted press.
- CLEAR_PULSE  output  1  one-cycle strobe when a long press clears the count.

Behaviour:
- Reset (async, RST=1):
  - LED_OUT=0, DEBOUNCED=0, PRESS_PULSE=0, CLEAR_PULSE=0.
  - Synchroniser flops=0, debounce counter=0, hold counter=0, FSM=IDLE.
  - Outputs hold these values while RST=1.
- Synchroniser: two flops on BTN_IN. sync_q is the second flop.
- Debounce:
  - Counter increments every clock where sync_q != DEBOUNCED.
  - Counter returns to 0 on any clock where sync_q == DEBOUNCED, so a bounce restarts the count.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync_q still differing, DEBOUNCED <= sync_q on that edge and the counter returns to 0.
  - Latency from BTN_IN change to DEBOUNCED change is exactly 2+DEBOUNCE_CYCLES rising edges for a clean edge.
  - A pulse or glitch shorter than DEBOUNCE_CYCLES clocks at sync_q is never accepted.
- FSM states IDLE, PRESSED, LONG_HELD:
  - IDLE: on the edge where DEBOUNCED goes 0->1:
    - LED_OUT <= LED_OUT+1, modulo 256 (255 -> 0 wraps, no saturation).
    - PRESS_PULSE=1 for exactly the next cycle.
    - Hold counter <= 0; go to PRESSED.
  - PRESSED:
    - Hold counter increments each clock while DEBOUNCED=1.
    - DEBOUNCED falling (1->0): go to IDLE; LED_OUT keeps its value.
    - Hold counter reaches LONG_PRESS_CYCLES-1: LED_OUT <= 0, CLEAR_PULSE=1 for one cycle, go to LONG_HELD.
    - The increment from this same press is therefore discarded (count ends at 0).
  - LONG_HELD:
    - No further clears or increments.
    - DEBOUNCED falling: go to IDLE.
- PRESS_PULSE and CLEAR_PULSE are registered, never high in the same cycle, and never high for two consecutive cycles.
- Hold counter width is ceil(log2(LONG_PRESS_CYCLES)). Debounce counter width is ceil(log2(DEBOUNCE_CYCLES+1)). Neither counter may wrap before its terminal value.
- Reset mid-operation:
  - Any state or counter value returns to reset values asynchronously.
  - If BTN_IN is still high after RST falls, it is treated as a new press: counted after 2+DEBOUNCE_CYCLES edges.
- No combinational path from BTN_IN to any output.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=40, 12 MHz CLK):
- Reset: assert RST for 100 ns with BTN_IN=0, then release. Required: all outputs 0, remaining 0 for 100 idle cycles.
- Clean press: BTN_IN 0->1 held 20 cycles, then 0 for 20 cycles. Required:
  - DEBOUNCED rises exactly 6 edges after the change.
  - LED_OUT goes 0->1 on that edge and PRESS_PULSE is high 1 cycle.
  - DEBOUNCED falls 6 edges after release; LED_OUT stays 1.
- Bounce: BTN_IN toggles 1,0,1,0 with each level held 2 cycles, then steady 1. Required: exactly one PRESS_PULSE, LED_OUT +1 only; a standalone 3-cycle high glitch gives no change.
- Wrap: 256 clean presses from reset. Required: LED_OUT reads 255 after press 255 and 0 after press 256; PRESS_PULSE count = 256.
- Long press: from LED_OUT=5, hold BTN_IN high 100 cycles. Required:
  - LED_OUT goes 6, then 0 when the hold counter reaches 39, i.e. 45 edges after the BTN_IN rise.
  - CLEAR_PULSE appears once; no second clear before release.
  - The next press gives LED_OUT=1.
- Reset mid-press: assert RST while in PRESSED with BTN_IN held high, release after 5 cycles. Required:
  - Outputs are 0 immediately on RST.
  - LED_OUT becomes 1 exactly 6 edges after RST falls.
